modinv_requester: RTL and testbench

- Initiator side of the modInv go/valid interface.
- Accepts modulus jobs from an upstream valid/ready port and rejects even moduli without launching the engine.
- For odd moduli, drives `go`/`n` to the modInv engine, waits for its `valid`, captures the 64-bit Montgomery constant (n' = -n^-1 mod 2^64) and returns it downstream with an error code.
- Sits between the Paillier key-setup controller and modInv; enforces one outstanding job, a timeout, and an idle gap between jobs.

---
 rtl/modinv_requester.sv | 100 ++++++++++
 tb/tb_modinv_requester.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/modinv_requester.sv
// modinv_requester: go/valid initiator for the modInv engine.
// Rejects even moduli, launches odd ones with an active-low go, captures n' = -n^-1 mod 2^INV_W,
// enforces a wait timeout and an idle gap between launches.
// Optional MODINV_CHECK_EN: registered self-check that n * n' == all-ones, flagging resp_err=11.
module modinv_requester #(
  parameter int N_W         = 4096,
  parameter int INV_W       = 64,
  parameter int TIMEOUT_CYC = 50000,
  parameter int GAP_CYC     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_W-1:0]   req_n,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [INV_W-1:0] resp_inv,
  output logic [1:0]       resp_err,
  output logic             busy,
  output logic             mi_go,
  output logic [N_W-1:0]   mi_n,
  input  logic [INV_W-1:0] mi_inv,
  input  logic             mi_valid
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [2:0] {IDLE, WAIT, CHK, RESP, GAP} state_t;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
`ifdef MODINV_CHECK_EN
  logic [INV_W-1:0] prod;
  assign prod = mi_n[INV_W-1:0] * resp_inv;
`endif
  // job sequencing: accept, launch, capture or time out, hold response, then enforce the idle gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      mi_go      <= 1'b1;
      mi_n       <= '0;
      resp_valid <= 1'b0;
      resp_inv   <= '0;
      resp_err   <= 2'b00;
      tcnt       <= '0;
      gcnt       <= '0;
    end else
      case (state)
        IDLE: if (req_valid)
          if (!req_n[0]) begin
            resp_err   <= 2'b01;
            resp_inv   <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mi_n  <= req_n;
            mi_go <= 1'b0;
            tcnt  <= '0;
            state <= WAIT;
          end
        WAIT: if (mi_valid) begin
            mi_go    <= 1'b1;
            resp_inv <= mi_inv;
            resp_err <= 2'b00;
`ifdef MODINV_CHECK_EN
            state    <= CHK;
`else
            resp_valid <= 1'b1;
            state      <= RESP;
`endif
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            mi_go      <= 1'b1;
            resp_inv   <= '0;
            resp_err   <= 2'b10;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else
            tcnt <= tcnt + 1'b1;
        CHK: begin
`ifdef MODINV_CHECK_EN
          resp_err   <= &prod ? 2'b00 : 2'b11;
`endif
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
            resp_valid <= 1'b0;
            gcnt       <= '0;
            state      <= GAP;
          end
        GAP:
          if (gcnt >= GW'(GAP_CYC - 1) && !mi_valid)
            state <= IDLE;
          else if (gcnt < GW'(GAP_CYC - 1))
            gcnt <= gcnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_modinv_requester.sv
// tb_modinv_requester: randomized jobs against a timeline model of the requester, plus literal pins.
module tb_modinv_requester;
  localparam int N_W = 4096;
  localparam int TO  = 16;
  localparam int GAP = 2;
`ifdef MODINV_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, resp_valid, resp_ready, busy, mi_go, mi_valid;
  logic [N_W-1:0] req_n, mi_n;
  logic [63:0] resp_inv, mi_inv;
  logic [1:0] resp_err;
  modinv_requester #(.N_W(N_W), .INV_W(64), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inv(resp_inv), .resp_err(resp_err),
    .busy(busy), .mi_go(mi_go), .mi_n(mi_n), .mi_inv(mi_inv), .mi_valid(mi_valid)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int chks = 0, errs = 0;
  bit chk_on = 1'b0;
  int j_a = -100, j_c = -100, j_r = -100, j_h = -100, j_e = -100;
  bit j_odd = 1'b0;
  logic [63:0] j_inv = '0, last_inv = '0;
  logic [1:0] j_err = '0, last_err = '0;
  logic [N_W-1:0] mi_pre = '0, mi_post = '0;
  int go_low = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  function automatic logic [63:0] ninv(input logic [63:0] n);
    logic [63:0] x;
    x = n;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - n * x);
    return -x;
  endfunction
  function automatic logic [N_W-1:0] rnd_n();
    logic [N_W-1:0] r;
    for (int i = 0; i < N_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction
  // per-cycle comparison of every output against the job timeline
  always @(negedge clk) if (chk_on) begin
    int p;
    bit in_job, e_rv;
    p = cyc;
    in_job = p >= j_a && p < j_e;
    e_rv = in_job && p >= j_r && p < j_h;
    chk("req_ready", req_ready, !in_job);
    chk("busy", busy, in_job);
    chk("mi_go", mi_go, !(in_job && j_odd && p < j_c));
    chk("resp_valid", resp_valid, e_rv);
    if (e_rv) begin
      chk("resp_inv", resp_inv, j_inv);
      chk("resp_err", resp_err, j_err);
    end
    chks++;
    if (mi_n !== (p >= j_a ? mi_post : mi_pre)) begin
      errs++;
      $display("FAIL mi_n at cycle %0d: got low %h expected low %h", p, mi_n[63:0],
               p >= j_a ? mi_post[63:0] : mi_pre[63:0]);
    end
    if (mi_go === 1'b0) go_low++;
    if (p == j_h - 1) begin
      last_inv = resp_inv;
      last_err = resp_err;
    end
  end
  // one job: derive its timeline from the rules, then drive inputs along it
  task automatic run_job(input logic [N_W-1:0] n, input bit hv, input int voff, input int hold,
                         input logic [63:0] v, input int d, input int idle);
    int a, vs, ve, last;
    bit cap;
    a = cyc + 1 + idle;
    vs = hv ? a + voff : -1000;
    ve = hv ? vs + hold - 1 : -1000;
    cap = n[0] && hv && vs <= a + TO;
    j_a = a;
    j_odd = n[0];
    j_c = !n[0] ? a : cap ? vs : a + TO;
    j_r = (cap && CK) ? j_c + 1 : j_c;
    j_h = j_r + d + 1;
    j_e = (j_h + GAP >= vs && j_h + GAP <= ve) ? ve + 1 : j_h + GAP;
    j_inv = cap ? v : '0;
    j_err = !n[0] ? 2'b01 : !cap ? 2'b10 : (CK && n[63:0] * v != '1) ? 2'b11 : 2'b00;
    mi_pre = mi_post;
    mi_post = n[0] ? n : mi_pre;
    go_low = 0;
    last = j_e > ve + 1 ? j_e : ve + 1;
    while (cyc < last) begin
      req_valid = cyc == a - 1;
      req_n = cyc == a - 1 ? n : rnd_n();
      mi_valid = cyc >= vs - 1 && cyc <= ve - 1;
      mi_inv = cyc == vs - 1 ? v : {$urandom(), $urandom()};
      resp_ready = cyc == j_h - 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mi_valid = 1'b0;
    resp_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_n = '0; resp_ready = 1'b0; mi_inv = '0; mi_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mi_go", mi_go, 1);
    chk("rst_mi_n", mi_n[63:0], 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_inv", resp_inv, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("model_ninv3", ninv(64'd3), 64'h5555555555555555);
    chk("model_ninv1", ninv(64'd1), 64'hFFFFFFFFFFFFFFFF);
    chk_on = 1'b1;
    run_job(1, 1, 12, 1, 64'hFFFFFFFFFFFFFFFF, 2, 0);
    chk("n1_go_low", go_low, 12);
    chk("n1_inv", last_inv, 64'hFFFFFFFFFFFFFFFF);
    chk("n1_err", last_err, 0);
    run_job(3, 1, 5, 1, 64'h5555555555555555, 0, 1);
    chk("n3_err", last_err, 0);
    chk("n3_inv", last_inv, 64'h5555555555555555);
    run_job(16, 0, 0, 0, 0, 1, 0);
    chk("even_go_low", go_low, 0);
    chk("even_err", last_err, 1);
    chk("even_inv", last_inv, 0);
    run_job(7, 0, 0, 0, 0, 3, 0);
    chk("to_go_low", go_low, TO);
    chk("to_err", last_err, 2);
    run_job(5, 1, 4, 5, ninv(64'd5), 5, 0);
    chk("hold_err", last_err, 0);
    run_job(11, 1, 3, 5, ninv(64'd11), 0, 0);
    run_job(13, 1, TO, 1, ninv(64'd13), 1, 0);
    chk("prio_go_low", go_low, TO);
    chk("prio_err", last_err, 0);
    chk_on = 1'b0;
    req_valid = 1'b1; req_n = N_W'(9);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_wait_go", mi_go, 0);
    chk("mid_wait_busy", busy, 1);
    chk("mid_wait_mi_n", mi_n[63:0], 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_go", mi_go, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mi_n", mi_n[63:0], 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mi_pre = '0; mi_post = '0; j_a = -100; j_e = -100; j_h = -100;
    chk_on = 1'b1;
    run_job(3, 1, 6, 1, 64'h1234, 1, 0);
    chk("post_rst_err", last_err, CK ? 2'b11 : 2'b00);
    chk("post_rst_inv", last_inv, 64'h1234);
    for (int k = 0; k < 60; k++) begin
      logic [N_W-1:0] n;
      logic [63:0] v;
      n = rnd_n();
      n[0] = $urandom_range(0, 4) != 0;
      v = $urandom_range(0, 1) != 0 ? ninv(n[63:0]) : {$urandom(), $urandom()};
      run_job(n, $urandom_range(0, 9) != 0, $urandom_range(1, 20), $urandom_range(1, 6), v,
              $urandom_range(0, 4), $urandom_range(0, 3));
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
